// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared geometry constants and fetch FSM encoding for the text overlay
package text_pkg;

    localparam int TXT_COLS = 16;
    localparam int TXT_ROWS = 16;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int CODE_W   = 7;
    localparam int XY_W     = 8;
    localparam int COL_W    = $clog2(TXT_COLS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/char_line_buffer.sv
// rtl/char_line_buffer.sv - 16-entry character code line buffer, one write port, async read
module char_line_buffer
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [COL_W-1:0]  i_waddr,
    input  logic [CODE_W-1:0] i_wdata,
    input  logic [COL_W-1:0]  i_raddr,
    output logic [CODE_W-1:0] o_rdata
);

    logic [CODE_W-1:0] r_mem [TXT_COLS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TXT_COLS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/text_row_prefetch.sv
// rtl/text_row_prefetch.sv - fetches one text row from the character ROM during hblank
// and serves code/glyph line/glyph column to the font renderer during active video.
module text_row_prefetch
    import text_pkg::*;
#(
    parameter int XPOS    = 336,
    parameter int YPOS    = 172,
    parameter int V_TOTAL = 628
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       hcount,
    input  logic [10:0]       vcount,
    input  logic              hblnk,
    input  logic              vblnk,
    output logic [XY_W-1:0]   char_xy,
    input  logic [CODE_W-1:0] char_code,
    output logic [CODE_W-1:0] code_out,
    output logic [3:0]        char_line,
    output logic [2:0]        char_col,
    output logic              text_en,
    output logic              busy
);

    localparam logic [10:0] X_ORG   = 11'(XPOS);
    localparam logic [10:0] Y_ORG   = 11'(YPOS);
    localparam logic [11:0] X_START = 12'(XPOS);
    localparam logic [11:0] X_END   = 12'(XPOS + TXT_COLS * GLYPH_W);
    localparam logic [11:0] Y_START = 12'(YPOS);
    localparam logic [11:0] Y_END   = 12'(YPOS + TXT_ROWS * GLYPH_H);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);

    fetch_state_t      r_state;
    logic [3:0]        r_row;
    logic [COL_W-1:0]  r_col;
    logic [COL_W-1:0]  r_col_d;
    logic              r_we_d;
    logic [XY_W-1:0]   r_char_xy;
    logic              r_busy;
    logic              r_hblnk_d;

    logic [CODE_W-1:0] r_code_out;
    logic [3:0]        r_char_line;
    logic [2:0]        r_char_col;
    logic              r_text_en;

    logic [10:0]       w_nline;
    logic [7:0]        w_noff;
    logic              w_row_hit;
    logic              w_trigger;
    logic              w_in_box;
    logic [6:0]        w_hoff;
    logic [3:0]        w_voff;
    logic [CODE_W-1:0] w_rd_data;

    assign w_nline   = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
    assign w_noff    = 8'(w_nline - Y_ORG);
    assign w_row_hit = ({1'b0, w_nline} >= Y_START) && ({1'b0, w_nline} < Y_END)
                     && (w_noff[3:0] == 4'd0);
    // Not gated by vblnk so that row 0 is loaded on the last blanked line.
    assign w_trigger = hblnk && !r_hblnk_d && w_row_hit;

    // Offsets are only consumed once the box compare has passed.
    assign w_hoff   = 7'(hcount - X_ORG);
    assign w_voff   = 4'(vcount - Y_ORG);
    assign w_in_box = ({1'b0, hcount} >= X_START) && ({1'b0, hcount} < X_END)
                    && ({1'b0, vcount} >= Y_START) && ({1'b0, vcount} < Y_END)
                    && !hblnk && !vblnk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_col_d   <= '0;
            r_we_d    <= 1'b0;
            r_char_xy <= '0;
            r_busy    <= 1'b0;
            r_hblnk_d <= 1'b0;
        end else begin
            r_hblnk_d <= hblnk;
            r_we_d    <= (r_state == ST_FETCH);
            r_col_d   <= r_col;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_state   <= ST_FETCH;
                        r_row     <= w_noff[7:4];
                        r_col     <= '0;
                        r_char_xy <= {w_noff[7:4], 4'd0};
                        r_busy    <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    // r_col is the column currently on char_xy.
                    if (r_col == 4'hF) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_col     <= r_col + 4'd1;
                        r_char_xy <= {r_row, r_col + 4'd1};
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    char_line_buffer u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (r_we_d),
        .i_waddr (r_col_d),
        .i_wdata (char_code),
        .i_raddr (w_hoff[6:3]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_out  <= '0;
            r_char_line <= '0;
            r_char_col  <= '0;
            r_text_en   <= 1'b0;
        end else begin
            r_text_en   <= w_in_box;
            r_code_out  <= w_in_box ? w_rd_data   : '0;
            r_char_line <= w_in_box ? w_voff      : '0;
            r_char_col  <= w_in_box ? w_hoff[2:0] : '0;
        end
    end

    assign char_xy   = r_char_xy;
    assign busy      = r_busy;
    assign code_out  = r_code_out;
    assign char_line = r_char_line;
    assign char_col  = r_char_col;
    assign text_en   = r_text_en;

endmodule

// File: tb/tb_text_row_prefetch.sv
// tb/tb_text_row_prefetch.sv - directed bench for text_row_prefetch with a synchronous ROM model
module tb_text_row_prefetch;

    localparam int XP = 336;
    localparam int YP = 172;
    localparam int VT = 628;

    logic        clk;
    logic        rst_n;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;

    logic [7:0]  char_xy;
    logic [6:0]  rom_q;
    logic [6:0]  code_out;
    logic [3:0]  char_line;
    logic [2:0]  char_col;
    logic        text_en;
    logic        busy;

    logic [7:0]  w_char_xy;
    logic [6:0]  w_rom_q;
    logic [6:0]  w_code_out;
    logic [3:0]  w_char_line;
    logic [2:0]  w_char_col;
    logic        w_text_en;
    logic        w_busy;

    int rom_mode;
    int n_checks;
    int n_fail;

    text_row_prefetch #(.XPOS(XP), .YPOS(YP), .V_TOTAL(VT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .hblnk     (hblnk),
        .vblnk     (vblnk),
        .char_xy   (char_xy),
        .char_code (rom_q),
        .code_out  (code_out),
        .char_line (char_line),
        .char_col  (char_col),
        .text_en   (text_en),
        .busy      (busy)
    );

    text_row_prefetch #(.XPOS(XP), .YPOS(0), .V_TOTAL(VT)) u_dut_wrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .hblnk     (hblnk),
        .vblnk     (vblnk),
        .char_xy   (w_char_xy),
        .char_code (w_rom_q),
        .code_out  (w_code_out),
        .char_line (w_char_line),
        .char_col  (w_char_col),
        .text_en   (w_text_en),
        .busy      (w_busy)
    );

    function automatic logic [6:0] rom_fn(input logic [7:0] a, input int mode);
        if (mode == 0) return (a == 8'h00) ? 7'h38 : 7'h31;
        return (a[7:4] == 4'd5) ? 7'(7'h20 + {3'b000, a[3:0]}) : 7'h7F;
    endfunction

    always @(posedge clk) begin
        rom_q   <= rom_fn(char_xy, rom_mode);
        w_rom_q <= rom_fn(w_char_xy, 0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1; hblnk = 1'b0; vblnk = 1'b0; rom_mode = 0;
        hcount = 11'(XP + 20); vcount = 11'(YP + 3);
        #2 rst_n = 1'b0;
        tick; tick;
        n_checks++; if (char_xy !== 8'h00) begin n_fail++; $display("FAIL reset char_xy got %h exp 00", char_xy); end
        n_checks++; if (code_out !== 7'h00) begin n_fail++; $display("FAIL reset code_out got %h exp 00", code_out); end
        n_checks++; if (char_line !== 4'h0) begin n_fail++; $display("FAIL reset char_line got %h exp 0", char_line); end
        n_checks++; if (char_col !== 3'h0) begin n_fail++; $display("FAIL reset char_col got %h exp 0", char_col); end
        n_checks++; if (text_en !== 1'b0) begin n_fail++; $display("FAIL reset text_en got %b exp 0", text_en); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", busy); end
        n_checks++; if (w_busy !== 1'b0) begin n_fail++; $display("FAIL reset wrap busy got %b exp 0", w_busy); end
        rst_n = 1'b1;
        tick;
        n_checks++; if (text_en !== 1'b1) begin n_fail++; $display("FAIL post-reset text_en got %b exp 1", text_en); end
        n_checks++; if (code_out !== 7'h00) begin n_fail++; $display("FAIL post-reset code_out got %h exp 00", code_out); end
        n_checks++; if (char_line !== 4'd3) begin n_fail++; $display("FAIL post-reset char_line got %0d exp 3", char_line); end
        n_checks++; if (char_col !== 3'd4) begin n_fail++; $display("FAIL post-reset char_col got %0d exp 4", char_col); end
        hblnk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post-reset no-trigger busy got %b exp 0", busy); end
        end
        hblnk = 1'b0;
        tick;
    endtask

    task automatic test_row0_fetch;
        logic [6:0] exp_code;
        logic [2:0] exp_col;
        logic       exp_en;
        rom_mode = 0;
        hcount = 11'd0; vcount = 11'(YP - 1); hblnk = 1'b0;
        tick;
        hblnk = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick;
            if (k <= 15) begin
                n_checks++; if (char_xy !== 8'(k)) begin n_fail++; $display("FAIL row0 char_xy cyc=%0d got %h exp %h", k, char_xy, 8'(k)); end
            end
            n_checks++; if (busy !== (k <= 16)) begin n_fail++; $display("FAIL row0 busy cyc=%0d got %b exp %b", k, busy, (k <= 16)); end
        end
        hblnk = 1'b0; vcount = 11'(YP);
        for (int h = XP - 1; h <= XP + 128; h++) begin
            hcount = 11'(h);
            tick;
            exp_en   = (h >= XP) && (h < XP + 128);
            exp_code = !exp_en ? 7'h00 : ((h - XP) < 8 ? 7'h38 : 7'h31);
            exp_col  = exp_en ? 3'((h - XP) % 8) : 3'd0;
            n_checks++; if (text_en !== exp_en) begin n_fail++; $display("FAIL row0 text_en h=%0d got %b exp %b", h, text_en, exp_en); end
            n_checks++; if (code_out !== exp_code) begin n_fail++; $display("FAIL row0 code_out h=%0d got %h exp %h", h, code_out, exp_code); end
            n_checks++; if (char_col !== exp_col) begin n_fail++; $display("FAIL row0 char_col h=%0d got %0d exp %0d", h, char_col, exp_col); end
            n_checks++; if (char_line !== 4'd0) begin n_fail++; $display("FAIL row0 char_line h=%0d got %0d exp 0", h, char_line); end
        end
    endtask

    task automatic test_mid_row;
        logic [6:0] exp_code;
        hcount = 11'd0; vcount = 11'(YP + 4); hblnk = 1'b0;
        tick;
        hblnk = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick;
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrow busy cyc=%0d got %b exp 0", k, busy); end
        end
        hblnk = 1'b0;
        for (int c = 0; c < 16; c++) begin
            hcount = 11'(XP + 8 * c + 3);
            tick;
            exp_code = (c == 0) ? 7'h38 : 7'h31;
            n_checks++; if (code_out !== exp_code) begin n_fail++; $display("FAIL midrow code_out col=%0d got %h exp %h", c, code_out, exp_code); end
            n_checks++; if (char_line !== 4'd4) begin n_fail++; $display("FAIL midrow char_line col=%0d got %0d exp 4", c, char_line); end
        end
    endtask

    task automatic test_row5_exit;
        logic [6:0] exp_code;
        rom_mode = 1;
        hcount = 11'd0; vcount = 11'(YP + 79); hblnk = 1'b0;
        tick;
        hblnk = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick;
            if (k <= 15) begin
                n_checks++; if (char_xy !== 8'(8'h50 + k)) begin n_fail++; $display("FAIL row5 char_xy cyc=%0d got %h exp %h", k, char_xy, 8'(8'h50 + k)); end
            end
            n_checks++; if (busy !== (k <= 16)) begin n_fail++; $display("FAIL row5 busy cyc=%0d got %b exp %b", k, busy, (k <= 16)); end
        end
        hblnk = 1'b0; vcount = 11'(YP + 80);
        for (int c = 0; c < 16; c++) begin
            hcount = 11'(XP + 8 * c + 7);
            tick;
            exp_code = 7'(7'h20 + c);
            n_checks++; if (code_out !== exp_code) begin n_fail++; $display("FAIL row5 code_out col=%0d got %h exp %h", c, code_out, exp_code); end
            n_checks++; if (char_col !== 3'd7) begin n_fail++; $display("FAIL row5 char_col col=%0d got %0d exp 7", c, char_col); end
        end
        hcount = 11'(XP + 128);
        tick;
        n_checks++; if (text_en !== 1'b0) begin n_fail++; $display("FAIL exit text_en got %b exp 0", text_en); end
        n_checks++; if (code_out !== 7'h00) begin n_fail++; $display("FAIL exit code_out got %h exp 00", code_out); end
        n_checks++; if (char_col !== 3'd0) begin n_fail++; $display("FAIL exit char_col got %0d exp 0", char_col); end
        hcount = 11'(XP + 40); hblnk = 1'b1;
        tick;
        n_checks++; if (text_en !== 1'b0) begin n_fail++; $display("FAIL hblank text_en got %b exp 0", text_en); end
        hblnk = 1'b0; vblnk = 1'b1;
        tick;
        n_checks++; if (text_en !== 1'b0) begin n_fail++; $display("FAIL vblank text_en got %b exp 0", text_en); end
        vblnk = 1'b0;
        tick;
    endtask

    task automatic test_vertical_wrap;
        hcount = 11'd0; vcount = 11'(VT - 1); hblnk = 1'b0; vblnk = 1'b1;
        tick;
        hblnk = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick;
            if (k <= 15) begin
                n_checks++; if (w_char_xy !== 8'(k)) begin n_fail++; $display("FAIL wrap char_xy cyc=%0d got %h exp %h", k, w_char_xy, 8'(k)); end
            end
            n_checks++; if (w_busy !== (k <= 16)) begin n_fail++; $display("FAIL wrap busy cyc=%0d got %b exp %b", k, w_busy, (k <= 16)); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrap main busy cyc=%0d got %b exp 0", k, busy); end
        end
        hblnk = 1'b0; vblnk = 1'b0; vcount = 11'd0; hcount = 11'(XP + 9);
        tick;
        n_checks++; if (w_code_out !== 7'h31) begin n_fail++; $display("FAIL wrap code_out got %h exp 31", w_code_out); end
    endtask

    task automatic test_reset_mid_fetch;
        logic [6:0] exp_code;
        rom_mode = 0;
        hcount = 11'd0; vcount = 11'(YP - 1); hblnk = 1'b0;
        tick;
        hblnk = 1'b1;
        for (int k = 0; k <= 6; k++) tick;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midfetch pre-reset busy got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midfetch busy got %b exp 0", busy); end
        n_checks++; if (char_xy !== 8'h00) begin n_fail++; $display("FAIL midfetch char_xy got %h exp 00", char_xy); end
        hblnk = 1'b0;
        tick;
        rst_n = 1'b1;
        vcount = 11'(YP);
        for (int c = 0; c < 16; c++) begin
            hcount = 11'(XP + 8 * c);
            tick;
            n_checks++; if (code_out !== 7'h00) begin n_fail++; $display("FAIL cleared code_out col=%0d got %h exp 00", c, code_out); end
            n_checks++; if (text_en !== 1'b1) begin n_fail++; $display("FAIL cleared text_en col=%0d got %b exp 1", c, text_en); end
        end
        hcount = 11'd0; vcount = 11'(YP - 1);
        tick;
        hblnk = 1'b1;
        for (int k = 0; k <= 17; k++) begin
            tick;
            n_checks++; if (busy !== (k <= 16)) begin n_fail++; $display("FAIL refetch busy cyc=%0d got %b exp %b", k, busy, (k <= 16)); end
        end
        hblnk = 1'b0; vcount = 11'(YP);
        for (int c = 0; c < 16; c++) begin
            hcount = 11'(XP + 8 * c + 5);
            tick;
            exp_code = (c == 0) ? 7'h38 : 7'h31;
            n_checks++; if (code_out !== exp_code) begin n_fail++; $display("FAIL refetch code_out col=%0d got %h exp %h", c, code_out, exp_code); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_row0_fetch;
        test_mid_row;
        test_row5_exit;
        test_vertical_wrap;
        test_reset_mid_fetch;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/text_row_prefetch.md
# text_row_prefetch

Text-overlay controller that sequences the 16×16 character-code ROM for the VGA display path. On each horizontal blank preceding a new text row, it walks the ROM address `char_xy` across the 16 columns of that row and captures the returned codes into a local line buffer. During active video it serves the current character code, glyph line and glyph column to the font renderer downstream. The ROM is therefore never accessed during active pixels.

## Interface
Parameters:
- `XPOS`, default 336: left pixel of the text box.
- `YPOS`, default 172: top line of the text box.
- `V_TOTAL`, default 628: lines per frame, used for `vcount` wrap.

Ports:
- `clk`, in, 1: pixel clock.
- `rst_n`, in, 1: reset. **Asynchronous, active-low.**
- `hcount`, in, 11: current pixel column.
- `vcount`, in, 11: current line.
- `hblnk`, in, 1: horizontal blank.
- `vblnk`, in, 1: vertical blank.
- `char_xy`, out, 8: ROM address `{row[3:0], col[3:0]}`, registered.
- `char_code`, in, 7: ROM data. Valid the cycle after `char_xy` is presented.
- `code_out`, out, 7: character code for the current pixel.
- `char_line`, out, 4: glyph line, equal to `(vcount-YPOS)[3:0]`.
- `char_col`, out, 3: glyph pixel column, equal to `(hcount-XPOS)[2:0]`.
- `text_en`, out, 1: current pixel lies inside the text box.
- `busy`, out, 1: fetch in progress.

## Operation
- **Geometry:**
  - 16 columns × 16 rows of characters.
  - Each glyph is 8 px wide × 16 lines tall.
  - The box spans `[XPOS, XPOS+128) × [YPOS, YPOS+256)`.
- **Next line:** `nline = (vcount == V_TOTAL-1) ? 0 : vcount+1`.
- **Trigger:** the rising edge of `hblnk` (registered `hblnk` 0→1) with `nline` in `[YPOS, YPOS+256)` and `(nline-YPOS)[3:0] == 0`.
  - The trigger is honoured regardless of `vblnk`, so row 0 is fetched on the last blank line.
  - The fetched row is `(nline-YPOS)[7:4]`.
- **State machine:**
  - IDLE → FETCH on trigger. Latch the row and set col=0.
  - FETCH: present `char_xy={row,col}` and increment col. When col=15 has been presented, go to DRAIN.
  - DRAIN: capture the last code, then return to IDLE.
- **Capture:** a one-stage delayed column index writes `char_code` into `buf[col_d]` in the cycle after each address.
- **No abort:** a fetch always completes. A trigger arriving while not in IDLE is ignored.
- **Display:** when `hcount` and `vcount` are inside the box and `hblnk`=`vblnk`=0:
  - `text_en`=1
  - `code_out=buf[(hcount-XPOS)[6:3]]`
  - `char_line` and `char_col` as defined in the Interface.
- **Outside the box:** `text_en`=0, and `code_out`, `char_line`, `char_col` are held at 0.
- **Width rule:** all offset subtractions are done in 11 bits and are used only after the in-box compare passes, so no underflow is visible.

## Timing
- **Fetch length:** 17 cycles from the trigger edge to `busy` falling. That is 16 address cycles plus 1 drain cycle.
- **`busy`:** high in FETCH and DRAIN.
- **ROM handshake:** address A driven on `char_xy` in cycle k yields the code on `char_code` in cycle k+1. It is written to `buf` at the end of k+1.
- **Display outputs:** registered, with 1-cycle latency from `hcount`/`vcount`/blank inputs.
- **Reset values:**
  - `char_xy`=0, `code_out`=0, `char_line`=0, `char_col`=0, `text_en`=0, `busy`=0.
  - FSM in IDLE.
  - All 16 buffer entries = 0.
- **Reset mid-fetch:** the FSM returns to IDLE immediately and the buffer is cleared. No resume; the next trigger refetches.

## Structure
- **Shared package `text_pkg`:**
  - `TXT_COLS=16`, `TXT_ROWS=16`, `GLYPH_W=8`, `GLYPH_H=16`.
  - `CODE_W=7`, `XY_W=8`.
  - FSM state encoding (IDLE, FETCH, DRAIN).
- **Sub-module `char_line_buffer`:** a 16×7 register file with one write port and one combinational read port, cleared on `rst_n`.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame → all outputs 0, `busy`=0. Release → no fetch until a valid trigger.
- **Row-0 fetch:** `hblnk` rises at `vcount`=YPOS-1, with a ROM model returning 0x38 at 0x00 and 0x31 elsewhere → `char_xy` steps 0x00..0x0F on consecutive cycles, `busy` is high for 17 cycles, then at line YPOS:
  - `code_out`=0x38 for hcount XPOS..XPOS+7
  - `code_out`=0x31 for XPOS+8..XPOS+127
  - `text_en`=1 throughout, each with 1-cycle latency.
- **Mid-row line:** `hblnk` rises at `vcount`=YPOS+4 → no fetch, `busy` stays 0, and the buffer is unchanged.
- **Vertical wrap:** with YPOS=0, `hblnk` rises at `vcount`=V_TOTAL-1 → a row-0 fetch occurs (`char_xy` 0x00..0x0F).
- **Row 5 and box exit:** a trigger at `nline`=YPOS+80 → `char_xy` 0x50..0x5F. At `hcount`=XPOS+128 → `text_en`=0, `code_out`=0.
- **Reset mid-fetch:** drop `rst_n` at fetch cycle 6 → `busy`=0 and all buffer reads return 0. The next trigger fetches all 16 entries again.
